sc_bit_serializer: RTL
======================

Name: sc_bit_serializer

Overview:
- Slow-clock-domain stage directly downstream of the 16-bit configuration FIFO; upstream of the MICROROC selected-register pins.
- Pops packed parameter words from the FIFO and serialises them MSB-first onto SR_IN with a generated SR_CK.
- Clears the chip register via SR_RSTB before every load.
- Supports two chain lengths: full slow control (592 bits) and read-scope (64 bits).

Parameters:
- SC_BITS, 592, slow-control chain length in bits; must be a multiple of 16.
- RS_BITS, 64, read-scope chain length in bits; must be a multiple of 16.
- RESET_CYCLES, 4, number of Clk cycles SR_RSTB is held low before shifting.
- STALL_TIMEOUT, 1024, consecutive empty-FIFO cycles allowed in FETCH before abort.

Ports:
- Clk  in  1  slow clock (5 MHz nominal); all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle start pulse (already synchronised into Clk).
- ChainSelect  in  1  0 = SC_BITS, 1 = RS_BITS; sampled with Start.
- FifoEmpty  in  1  FIFO empty flag.
- FifoData  in  16  FIFO dout, valid one cycle after FifoReadEn.
- FifoReadEn  out  1  FIFO read strobe.
- SR_CK  out  1  serial clock to chip.
- SR_RSTB  out  1  serial register reset, active low.
- SR_IN  out  1  serial data to chip.
- Busy  out  1  high from the cycle after Start until DONE/ERROR.
- Done  out  1  one-cycle pulse on successful completion.
- Error  out  1  one-cycle pulse on stall timeout.

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-high.
- All outputs are registered. Reset values:
  - SR_CK=0, SR_RSTB=1, SR_IN=0.
  - FifoReadEn=0, Busy=0, Done=0, Error=0.
  - State IDLE; counters cleared.
- IDLE:
  - On Start=1, latch the bit target (SC_BITS or RS_BITS per ChainSelect).
  - Next state RESET_SR; Busy=1.
  - Start while not IDLE is ignored.
- RESET_SR: SR_RSTB=0 for exactly RESET_CYCLES cycles, SR_CK=0; then SR_RSTB=1 and go to FETCH.
- FETCH:
  - If FifoEmpty=0: FifoReadEn=1 for one cycle, go to LOAD.
  - If FifoEmpty=1: hold SR_CK=0 and increment the stall counter.
  - Stall counter reaching STALL_TIMEOUT -> ERROR.
  - Stall counter clears on every successful read.
- LOAD: capture FifoData into the 16-bit shift register; bit index=15; go to CK_LOW.
- CK_LOW: SR_IN=shift[15], SR_CK=0.
- CK_HIGH:
  - SR_CK=1 with SR_IN held stable, so the chip samples on the SR_CK rising edge with one full Clk of setup.
  - Decrement the remaining-bit counter.
  - If remaining bits = 0 -> DONE.
  - Else if the word is exhausted (16 bits sent) -> FETCH.
  - Else shift left, back to CK_LOW.
- Timing: each bit costs 2 cycles, each word 34 cycles (FETCH+LOAD+32), so SR_CK = Clk/2 during a word.
- DONE: Done=1 for one cycle, SR_CK=0, SR_IN=0, Busy=0, go to IDLE.
- ERROR: Error=1 for one cycle, SR_CK=0, SR_RSTB=1, SR_IN=0, Busy=0, go to IDLE. Partial data already shifted stays in the chip; the FIFO is not flushed.
- Latency with no FIFO stalls, Start at cycle 0:
  - SC_BITS=592: RESET_SR cycles 1–4, 37 words over cycles 5–1262, Done at cycle 1263.
  - RS_BITS=64: Done at cycle 141.
- Remaining-bit counter is 10 bits; no wrap because the target is ≤ 1023.
- Surplus FIFO words beyond the target are left unread.
- reset asserted at any point forces the reset values immediately (asynchronous), with no Done or Error pulse.
- FifoReadEn is never asserted when FifoEmpty=1.
- FifoReadEn is asserted at most once per 34 cycles.

Test Plan:
1. FIFO preloaded with 37 words 0xA5C3, ChainSelect=0, Start at cycle 0 -> SR_RSTB low cycles 1–4; SR_IN per SR_CK rise repeats 1010010111000011; exactly 592 SR_CK rises; Done at cycle 1263; 37 FifoReadEn pulses.
2. ChainSelect=1, four words 0x8000,0x0000,0x0000,0x0001 -> 64 SR_CK rises; SR_IN=1 only on rises 1 and 64; Done at cycle 141; fifth FIFO word remains unread.
3. FIFO empties after word 10 and is refilled 200 cycles later -> SR_CK held 0 during the gap; stream resumes with the correct word; Done with no Error; total 592 bits.
4. FIFO empty for 1024 cycles in FETCH -> Error pulse exactly one cycle; Busy=0 next cycle; Done never asserted; SR_RSTB=1.
5. Second Start at cycle 500 during an SC load -> ignored; single Done at cycle 1263; bit count 592.
6. reset asserted at cycle 300 mid-shift -> outputs at reset values within the same cycle; no Done/Error; a new Start afterwards completes a normal load.

Source files
------------

// File: rtl/sc_bit_serializer.sv
// Slow-control bit serializer: pops 16-bit words from the config FIFO and shifts them
// MSB-first onto SR_IN with a generated SR_CK, after clearing the chip register via SR_RSTB.
module sc_bit_serializer #(
    parameter int unsigned SC_BITS       = 592,
    parameter int unsigned RS_BITS       = 64,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        ChainSelect,
    input  logic        FifoEmpty,
    input  logic [15:0] FifoData,
    output logic        FifoReadEn,
    output logic        SR_CK,
    output logic        SR_RSTB,
    output logic        SR_IN,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);
    localparam int unsigned RstW   = $clog2(RESET_CYCLES + 1);
    localparam int unsigned StallW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StResetSr, StFetch, StLoad, StCkLow, StCkHigh, StDone, StError
    } state_e;

    state_e             state_q, state_d;
    logic [9:0]         rem_q, rem_d;
    logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [StallW-1:0]  stall_q, stall_d;
    logic [3:0]         bit_idx_q, bit_idx_d;
    logic [15:0]        shift_q, shift_d;
    logic               rd_en_q, rd_en_d;
    logic               sr_ck_q, sr_ck_d;
    logic               sr_rstb_q, sr_rstb_d;
    logic               sr_in_q, sr_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        rst_cnt_d = rst_cnt_q;
        stall_d   = stall_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rd_en_d   = 1'b0;
        sr_ck_d   = sr_ck_q;
        sr_rstb_d = sr_rstb_q;
        sr_in_d   = sr_in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    rem_d     = ChainSelect ? 10'(RS_BITS) : 10'(SC_BITS);
                    rst_cnt_d = RstW'(RESET_CYCLES - 1);
                    stall_d   = '0;
                    sr_rstb_d = 1'b0;
                    sr_ck_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StResetSr;
                end
            end
            StResetSr: begin
                if (rst_cnt_q == '0) begin
                    sr_rstb_d = 1'b1;
                    // Read is issued on FETCH entry so data lands during LOAD.
                    rd_en_d   = ~FifoEmpty;
                    state_d   = StFetch;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            StFetch: begin
                sr_ck_d = 1'b0;
                if (rd_en_q) begin
                    stall_d = '0;
                    state_d = StLoad;
                end else if (!FifoEmpty) begin
                    rd_en_d = 1'b1;
                end else if (stall_q == StallW'(STALL_TIMEOUT - 1)) begin
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    sr_rstb_d = 1'b1;
                    sr_in_d   = 1'b0;
                    state_d   = StError;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            StLoad: begin
                shift_d   = FifoData;
                sr_in_d   = FifoData[15];
                bit_idx_d = 4'd15;
                state_d   = StCkLow;
            end
            StCkLow: begin
                sr_ck_d = 1'b1;
                state_d = StCkHigh;
            end
            StCkHigh: begin
                sr_ck_d = 1'b0;
                rem_d   = rem_q - 1'b1;
                if (rem_q == 10'd1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    sr_in_d = 1'b0;
                    state_d = StDone;
                end else if (bit_idx_q == 4'd0) begin
                    rd_en_d = ~FifoEmpty;
                    state_d = StFetch;
                end else begin
                    shift_d   = {shift_q[14:0], 1'b0};
                    sr_in_d   = shift_q[14];
                    bit_idx_d = bit_idx_q - 1'b1;
                    state_d   = StCkLow;
                end
            end
            StDone, StError: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            rst_cnt_q <= '0;
            stall_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rd_en_q   <= 1'b0;
            sr_ck_q   <= 1'b0;
            sr_rstb_q <= 1'b1;
            sr_in_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            rst_cnt_q <= rst_cnt_d;
            stall_q   <= stall_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rd_en_q   <= rd_en_d;
            sr_ck_q   <= sr_ck_d;
            sr_rstb_q <= sr_rstb_d;
            sr_in_q   <= sr_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign FifoReadEn = rd_en_q;
    assign SR_CK      = sr_ck_q;
    assign SR_RSTB    = sr_rstb_q;
    assign SR_IN      = sr_in_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Error      = error_q;

endmodule
